// File: rtl/uart_pkg.sv
// Shared UART definitions: check-bit modes, receiver FSM encodings and frame length.
// Used by uart_tx and uart_rx so both ends agree on frame layout.
package uart_pkg;

    localparam int UART_CHECK_NONE = 0;
    localparam int UART_CHECK_ODD  = 1;
    localparam int UART_CHECK_EVEN = 2;

    localparam logic [2:0] RX_WAIT_IDLE = 3'd0;
    localparam logic [2:0] RX_IDLE      = 3'd1;
    localparam logic [2:0] RX_DATA      = 3'd2;
    localparam logic [2:0] RX_CHECK     = 3'd3;
    localparam logic [2:0] RX_STOP      = 3'd4;

    // Edges from the first low line sample to the valid pulse: 2 synchronizer stages plus the frame body.
    function automatic int uart_frame_len(input int data_w, input int check, input int stop_w);
        return 2 + data_w + ((check != UART_CHECK_NONE) ? 1 : 0) + stop_w;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input, reset to a chosen value.
// Latency: 2 clocks. No backpressure.
module uart_rx_sync #(
    parameter logic P_RST_LEVEL = 1'b1,
    parameter logic P_RST_VAL   = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_sync
);

    logic rst_act;
    logic meta_q;
    logic sync_q;

    assign rst_act = (i_rst == P_RST_LEVEL);

    always_ff @(posedge i_clk or posedge rst_act) begin
        if (rst_act) begin
            meta_q <= P_RST_VAL;
            sync_q <= P_RST_VAL;
        end else begin
            meta_q <= i_async;
            sync_q <= meta_q;
        end
    end

    assign o_sync = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, one sample per bit-rate clock edge; UART_RX_ERR_DROP_EN suppresses valid on errored frames.
// Latency: valid in the cycle after edge 2+W+C+S counted from the first low line sample.
// No backpressure: the word is presented for exactly one cycle.
module uart_rx
    import uart_pkg::*;
#(
    parameter int P_SYSTEM_CLK      = 50_000_000,
    parameter int P_UART_BUADRATE   = 9600,
    parameter int P_UART_DATA_WIDTH = 8,
    parameter int P_UART_STOP_WIDTH = 1,
    parameter int P_UART_CHECK      = 0
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_uart_rx,
    output logic [P_UART_DATA_WIDTH-1:0] o_user_rx_data,
    output logic                         o_user_rx_valid,
    output logic                         o_rx_check_err,
    output logic                         o_rx_frame_err
);

    localparam int         L_W         = P_UART_DATA_WIDTH;
    localparam bit         L_HAS_CHECK = (P_UART_CHECK != UART_CHECK_NONE);
    localparam logic [3:0] L_DATA_LAST = 4'(P_UART_DATA_WIDTH - 1);
    localparam logic [3:0] L_STOP_LAST = 4'(P_UART_STOP_WIDTH - 1);

    if (P_UART_DATA_WIDTH < 5 || P_UART_DATA_WIDTH > 9) begin : g_bad_data_width
        $error("uart_rx: P_UART_DATA_WIDTH must be 5..9");
    end
    if (P_UART_STOP_WIDTH < 1 || P_UART_STOP_WIDTH > 2) begin : g_bad_stop_width
        $error("uart_rx: P_UART_STOP_WIDTH must be 1..2");
    end
    if (P_UART_CHECK < UART_CHECK_NONE || P_UART_CHECK > UART_CHECK_EVEN) begin : g_bad_check
        $error("uart_rx: P_UART_CHECK must be 0, 1 or 2");
    end
    if (P_UART_BUADRATE <= 0 || P_SYSTEM_CLK < P_UART_BUADRATE) begin : g_bad_rate
        $error("uart_rx: baud rate must be positive and not exceed the system clock");
    end

    logic           rx_s;
    logic [2:0]     state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [L_W-1:0] shift_q, shift_d;
    logic           par_q, par_d;
    logic           chk_err_q, chk_err_d;
    logic           frm_err_q, frm_err_d;
    logic [L_W-1:0] data_q, data_d;
    logic           valid_q, valid_d;
    logic           out_chk_q, out_chk_d;
    logic           out_frm_q, out_frm_d;
    logic           frm_now;

    uart_rx_sync #(
        .P_RST_LEVEL (1'b1),
        .P_RST_VAL   (1'b1)
    ) u_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_uart_rx),
        .o_sync  (rx_s)
    );

    assign frm_now = frm_err_q | ~rx_s;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        chk_err_d = chk_err_q;
        frm_err_d = frm_err_q;
        data_d    = data_q;
        valid_d   = 1'b0;
`ifdef UART_RX_ERR_DROP_EN
        out_chk_d = 1'b0;
        out_frm_d = 1'b0;
`else
        out_chk_d = out_chk_q;
        out_frm_d = out_frm_q;
`endif
        case (state_q)
            RX_WAIT_IDLE: begin
                if (rx_s) begin
                    state_d = RX_IDLE;
                end
            end
            RX_IDLE: begin
                if (!rx_s) begin
                    state_d   = RX_DATA;
                    cnt_d     = 4'd0;
                    par_d     = 1'b0;
                    chk_err_d = 1'b0;
                    frm_err_d = 1'b0;
                end
            end
            RX_DATA: begin
                // Shift in at the MSB so the first (LSB) bit ends up at bit 0.
                shift_d = {rx_s, shift_q[L_W-1:1]};
                par_d   = par_q ^ rx_s;
                if (cnt_q == L_DATA_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = L_HAS_CHECK ? RX_CHECK : RX_STOP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RX_CHECK: begin
                if (P_UART_CHECK == UART_CHECK_ODD) begin
                    chk_err_d = ((par_q ^ rx_s) != 1'b1);
                end else begin
                    chk_err_d = ((par_q ^ rx_s) != 1'b0);
                end
                state_d = RX_STOP;
            end
            RX_STOP: begin
                frm_err_d = frm_now;
                if (cnt_q == L_STOP_LAST) begin
                    cnt_d = 4'd0;
                    // A low stop bit may be a break; wait for the line to return high.
                    state_d = frm_now ? RX_WAIT_IDLE : RX_IDLE;
`ifdef UART_RX_ERR_DROP_EN
                    out_chk_d = chk_err_q;
                    out_frm_d = frm_now;
                    if (!(chk_err_q || frm_now)) begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                    end
`else
                    out_chk_d = chk_err_q;
                    out_frm_d = frm_now;
                    valid_d   = 1'b1;
                    data_d    = shift_q;
`endif
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = RX_WAIT_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= RX_WAIT_IDLE;
            cnt_q     <= 4'd0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            chk_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            out_chk_q <= 1'b0;
            out_frm_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            chk_err_q <= chk_err_d;
            frm_err_q <= frm_err_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            out_chk_q <= out_chk_d;
            out_frm_q <= out_frm_d;
        end
    end

    assign o_user_rx_data  = data_q;
    assign o_user_rx_valid = valid_q;
    assign o_rx_check_err  = out_chk_q;
    assign o_rx_frame_err  = out_frm_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: three receivers (check NONE/ODD/EVEN, W=8, S=1) driven one at a time.
// Expected words and their valid edges come from a frame-level model queue.
module tb_uart_rx;

    localparam int NDUT = 3;

    typedef struct {
        int         d;
        int         at_edge;
        logic [7:0] data;
        logic       ce;
        logic       fe;
    } exp_t;

    typedef struct {
        int         d;
        int         c;
        logic [7:0] data;
        logic       ce;
        logic       fe;
    } obs_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NDUT-1:0]      line;
    logic [NDUT-1:0][7:0] dat;
    logic [NDUT-1:0]      vld;
    logic [NDUT-1:0]      cerr;
    logic [NDUT-1:0]      ferr;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    obs_t obs_q[$];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        uart_rx #(
            .P_SYSTEM_CLK      (50_000_000),
            .P_UART_BUADRATE   (9600),
            .P_UART_DATA_WIDTH (8),
            .P_UART_STOP_WIDTH (1),
            .P_UART_CHECK      (g)
        ) u_dut (
            .i_clk           (clk),
            .i_rst           (rst),
            .i_uart_rx       (line[g]),
            .o_user_rx_data  (dat[g]),
            .o_user_rx_valid (vld[g]),
            .o_rx_check_err  (cerr[g]),
            .o_rx_frame_err  (ferr[g])
        );
    end

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Frame-level reference: valid edge = start + 2 sync stages + 8 data + check + 1 stop.
    function automatic exp_t model(input int d, input logic [7:0] data, input logic chkb,
                                   input logic stopb, input int start);
        exp_t e;
        int   ones;
        e.d       = d;
        e.data    = data;
        e.at_edge = start + 2 + 8 + ((d != 0) ? 1 : 0) + 1;
        ones      = $countones(data) + (chkb ? 1 : 0);
        if (d == 1)      e.ce = ((ones % 2) != 1);
        else if (d == 2) e.ce = ((ones % 2) != 0);
        else             e.ce = 1'b0;
        e.fe = ~stopb;
        return e;
    endfunction

    function automatic obs_t nth_last(input int d, input int n);
        obs_t o;
        int   k;
        o.d = d; o.c = -1; o.data = 8'h00; o.ce = 1'b0; o.fe = 1'b0;
        k = n;
        for (int i = obs_q.size() - 1; i >= 0; i--) begin
            if (obs_q[i].d == d) begin
                if (k == 0) return obs_q[i];
                k--;
            end
        end
        return o;
    endfunction

    // Drives one line bit; the first DUT edge to see it is cyc+1 on return.
    task automatic send_bit(input int d, input logic b);
        @(posedge clk);
        #1;
        line    = '1;
        line[d] = b;
    endtask

    task automatic idle(input int d, input int n);
        for (int i = 0; i < n; i++) send_bit(d, 1'b1);
    endtask

    task automatic send_frame(input int d, input logic [7:0] data, input logic chkb,
                              input logic stopb, input int gap, output int start, output exp_t e);
        send_bit(d, 1'b0);
        start = cyc + 1;
        e     = model(d, data, chkb, stopb, start);
        q.push_back(e);
        for (int i = 0; i < 8; i++) send_bit(d, data[i]);
        if (d != 0) send_bit(d, chkb);
        send_bit(d, stopb);
        for (int i = 0; i < gap; i++) send_bit(d, 1'b1);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < NDUT; d++) begin
                logic hit;
                logic expv;
                hit  = (q.size() > 0) && (q[0].d == d) && (q[0].at_edge == cyc);
                expv = hit;
`ifdef UART_RX_ERR_DROP_EN
                if (hit && (q[0].ce || q[0].fe)) expv = 1'b0;
`endif
                chk($sformatf("valid[%0d]", d), 32'(vld[d]), 32'(expv));
                if (hit) begin
                    if (expv) chk($sformatf("data[%0d]", d), 32'(dat[d]), 32'(q[0].data));
                    chk($sformatf("check_err[%0d]", d), 32'(cerr[d]), 32'(q[0].ce));
                    chk($sformatf("frame_err[%0d]", d), 32'(ferr[d]), 32'(q[0].fe));
                end
                if (vld[d]) obs_q.push_back('{d, cyc, dat[d], cerr[d], ferr[d]});
            end
            while (q.size() > 0 && q[0].at_edge <= cyc) q.delete(0);
        end
    end

    initial begin
        exp_t       e;
        obs_t       o;
        obs_t       o2;
        int         s;
        int         s2;
        int         dd;
        int         gap;
        logic [7:0] v;
        logic       cb;
        logic       sb;

        line = '1;
        rst  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("rst_valid[%0d]", d), 32'(vld[d]), 32'd0);
            chk($sformatf("rst_data[%0d]", d), 32'(dat[d]), 32'd0);
            chk($sformatf("rst_cerr[%0d]", d), 32'(cerr[d]), 32'd0);
            chk($sformatf("rst_ferr[%0d]", d), 32'(ferr[d]), 32'd0);
        end
        rst = 1'b0;
        idle(0, 3);

        // NONE: 0x55, latency pinned to 11 edges
        send_frame(0, 8'h55, 1'b0, 1'b1, 3, s, e);
        idle(0, 2);
        o = nth_last(0, 0);
        chk("lat_55", 32'(o.c - s), 32'd11);
        chk("data_55", 32'(o.data), 32'h55);
        chk("errs_55", 32'({o.ce, o.fe}), 32'd0);

        // ODD: 0xA3 with good and bad check bit
        send_frame(1, 8'hA3, 1'b1, 1'b1, 3, s, e);
        chk("model_a3_good", 32'(e.ce), 32'd0);
        idle(1, 2);
        o = nth_last(1, 0);
        chk("data_a3", 32'(o.data), 32'hA3);
        chk("cerr_a3_good", 32'(o.ce), 32'd0);
        send_frame(1, 8'hA3, 1'b0, 1'b1, 3, s, e);
        chk("model_a3_bad", 32'(e.ce), 32'd1);
        idle(1, 2);
        o = nth_last(1, 0);
`ifndef UART_RX_ERR_DROP_EN
        chk("cerr_a3_bad", 32'(o.ce), 32'd1);
        chk("lat_a3_odd", 32'(o.c - s), 32'd12);
`endif

        // EVEN: 0x07 with check 0 is an error
        send_frame(2, 8'h07, 1'b0, 1'b1, 3, s, e);
        chk("model_07", 32'(e.ce), 32'd1);
        idle(2, 2);
        o = nth_last(2, 0);
`ifndef UART_RX_ERR_DROP_EN
        chk("cerr_07", 32'(o.ce), 32'd1);
        chk("data_07", 32'(o.data), 32'h07);
`else
        chk("drop_07", 32'(o.c == e.at_edge), 32'd0);
`endif

        // Bad stop on 0x3C, line held low, then clean 0x81
        send_frame(0, 8'h3C, 1'b0, 1'b0, 0, s, e);
        for (int i = 0; i < 5; i++) send_bit(0, 1'b0);
        idle(0, 2);
        send_frame(0, 8'h81, 1'b0, 1'b1, 3, s, e);
        idle(0, 2);
        o = nth_last(0, 0);
        chk("data_81", 32'(o.data), 32'h81);
        chk("ferr_81", 32'(o.fe), 32'd0);
`ifndef UART_RX_ERR_DROP_EN
        o2 = nth_last(0, 1);
        chk("data_3c", 32'(o2.data), 32'h3C);
        chk("ferr_3c", 32'(o2.fe), 32'd1);
`endif

        // Back-to-back 0x00 then 0xFF, zero gap
        send_frame(0, 8'h00, 1'b0, 1'b1, 0, s, e);
        send_frame(0, 8'hFF, 1'b0, 1'b1, 3, s2, e);
        idle(0, 2);
        o  = nth_last(0, 1);
        o2 = nth_last(0, 0);
        chk("b2b_spacing", 32'(o2.c - o.c), 32'd10);
        chk("b2b_data0", 32'(o.data), 32'h00);
        chk("b2b_data1", 32'(o2.data), 32'hFF);

        // Reset during data bit 4 of 0x5A, then 0xC3
        v = 8'h5A;
        send_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(0, v[i]);
        send_bit(0, v[4]);
        rst  = 1'b1;
        line = '1;
        #1;
        chk("mid_rst_data", 32'(dat[0]), 32'd0);
        chk("mid_rst_valid", 32'(vld[0]), 32'd0);
        chk("mid_rst_errs", 32'({cerr[0], ferr[0]}), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(0, 3);
        send_frame(0, 8'hC3, 1'b0, 1'b1, 3, s, e);
        idle(0, 2);
        o = nth_last(0, 0);
        chk("data_c3", 32'(o.data), 32'hC3);
        chk("lat_c3", 32'(o.c - s), 32'd11);

        // Randomized frames across all three receivers
        for (int n = 0; n < 150; n++) begin
            dd  = $urandom_range(0, NDUT - 1);
            v   = 8'($urandom);
            cb  = (dd == 1) ? ~(^v) : (^v);
            if ($urandom_range(0, 3) == 0) cb = 1'($urandom);
            sb  = ($urandom_range(0, 6) != 0);
            gap = $urandom_range(0, 3);
            if (!sb && gap == 0) gap = 1;
            send_frame(dd, v, cb, sb, gap, s, e);
        end

        for (int i = 0; i < 40 && q.size() > 0; i++) @(posedge clk);
        #1;
        chk("drain", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
